// File: rtl/occupancy_monitor.sv
// occupancy_monitor: room-occupancy supervisor driving lights, full/lock, vacancy and a latched counter fault
module occupancy_monitor #(
    parameter int CAPACITY    = 6,
    parameter int HOLD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] pcount,
    input  logic       ack,
    output logic       lights,
    output logic       full,
    output logic       door_lock,
    output logic       fault,
    output logic [2:0] vacancy
);
    localparam int TW = $clog2(HOLD_CYCLES + 1);
    localparam logic [2:0] CAP = 3'(CAPACITY);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {EMPTY, OCCUPIED, FULL, VACATING, FAULT} state_t;

    state_t state_q, state_d;
    logic [2:0] prev_pcount_q, vacancy_q, vacancy_d, step;
    logic [TW-1:0] timer_q, timer_d;
    logic fault_ev, at_cap, nonzero;

    // any step larger than one also catches the 0<->7 wrap
    assign step     = pcount > prev_pcount_q ? pcount - prev_pcount_q : prev_pcount_q - pcount;
    assign fault_ev = step > 3'd1;
    assign at_cap   = pcount >= CAP;
    assign nonzero  = pcount != 3'd0;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            EMPTY:    state_d = at_cap ? FULL : nonzero ? OCCUPIED : EMPTY;
            OCCUPIED: begin
                state_d = at_cap ? FULL : nonzero ? OCCUPIED : VACATING;
                timer_d = nonzero ? timer_q : HOLD_LOAD;
            end
            FULL: begin
                state_d = !nonzero ? VACATING : at_cap ? FULL : OCCUPIED;
                timer_d = nonzero ? timer_q : HOLD_LOAD;
            end
            VACATING: begin
                state_d = nonzero ? (at_cap ? FULL : OCCUPIED) : timer_q == '0 ? EMPTY : VACATING;
                timer_d = (nonzero || timer_q == '0) ? timer_q : timer_q - TW'(1);
            end
            FAULT:    state_d = !ack ? FAULT : nonzero ? OCCUPIED : EMPTY;
            default:  state_d = EMPTY;
        endcase
        if (fault_ev) state_d = FAULT;
        vacancy_d = (state_d == FAULT || at_cap) ? 3'd0 : CAP - pcount;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= EMPTY;
            prev_pcount_q <= 3'd0;
            timer_q       <= '0;
            vacancy_q     <= CAP;
        end else begin
            state_q       <= state_d;
            prev_pcount_q <= pcount;
            timer_q       <= timer_d;
            vacancy_q     <= vacancy_d;
        end
    end

    assign lights    = state_q != EMPTY;
    assign full      = state_q == FULL;
    assign door_lock = state_q == FULL;
    assign fault     = state_q == FAULT;
    assign vacancy   = vacancy_q;
endmodule

// File: tb/tb_occupancy_monitor.sv
// tb_occupancy_monitor: directed stimulus checked every cycle against an occupancy/zero-run model
module tb_occupancy_monitor;
    localparam int CAP = 6;
    localparam int H   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] pcount = 3'd0;
    logic ack = 1'b0;
    logic lights, full, door_lock, fault;
    logic [2:0] vacancy;
    int n_cmp = 0;
    int n_bad = 0;

    occupancy_monitor #(.CAPACITY(CAP), .HOLD_CYCLES(H)) dut (
        .clk(clk), .rst(rst), .pcount(pcount), .ack(ack),
        .lights(lights), .full(full), .door_lock(door_lock), .fault(fault), .vacancy(vacancy)
    );

    always #5 clk = ~clk;

    // model: fault latch, last sample, consecutive zero samples since occupancy, fault-clear edge flag
    int m_prev = 0;
    int m_pc = 0;
    int m_zrun = H + 1;
    bit m_fault = 1'b0;
    bit m_clr = 1'b0;
    bit m_ev;

    assign m_ev = (int'(pcount) - m_prev > 1) || (m_prev - int'(pcount) > 1);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prev  <= 0;
            m_pc    <= 0;
            m_zrun  <= H + 1;
            m_fault <= 1'b0;
            m_clr   <= 1'b0;
        end else begin
            m_prev <= int'(pcount);
            m_pc   <= int'(pcount);
            m_clr  <= !m_ev && m_fault && ack;
            if (m_ev) m_fault <= 1'b1;
            else if (m_fault && ack) begin
                m_fault <= 1'b0;
                m_zrun  <= pcount == 3'd0 ? H + 1 : 0;
            end else if (!m_fault)
                m_zrun <= pcount != 3'd0 ? 0 : (m_zrun > H ? H + 1 : m_zrun + 1);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int e_full;
        e_full = (!m_fault && !m_clr && m_pc >= CAP) ? 1 : 0;
        chk("m_lights", int'(lights), (m_fault || m_zrun <= H) ? 1 : 0);
        chk("m_full", int'(full), e_full);
        chk("m_door_lock", int'(door_lock), e_full);
        chk("m_fault", int'(fault), int'(m_fault));
        chk("m_vacancy", int'(vacancy), m_fault ? 0 : (m_pc < CAP ? CAP - m_pc : 0));
    end

    task automatic step(input logic [2:0] p, input logic a);
        pcount = p;
        ack    = a;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        @(negedge clk);
        #1;
        chk("rst_lights", int'(lights), 0);
        chk("rst_vacancy", int'(vacancy), 6);
        rst = 1'b0;
        step(3'd0, 1'b0);
        chk("idle_lights", int'(lights), 0);
        chk("idle_vacancy", int'(vacancy), 6);
        // ramp up to capacity
        step(3'd1, 1'b0);
        chk("ramp1_lights", int'(lights), 1);
        chk("ramp1_vacancy", int'(vacancy), 5);
        for (int i = 2; i <= 5; i++) step(3'(i), 1'b0);
        chk("ramp5_full", int'(full), 0);
        step(3'd6, 1'b0);
        chk("ramp6_full", int'(full), 1);
        chk("ramp6_lock", int'(door_lock), 1);
        chk("ramp6_vacancy", int'(vacancy), 0);
        step(3'd5, 1'b0);
        chk("down5_full", int'(full), 0);
        chk("down5_vacancy", int'(vacancy), 1);
        // vacate with full hold
        for (int i = 4; i >= 1; i--) step(3'(i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(3'd0, 1'b0);
            chk("hold_lights", int'(lights), 1);
        end
        step(3'd0, 1'b0);
        chk("hold_expired", int'(lights), 0);
        // vacate, re-enter on the last hold cycle
        step(3'd1, 1'b0);
        for (int i = 0; i < 4; i++) step(3'd0, 1'b0);
        step(3'd1, 1'b0);
        chk("reenter_lights", int'(lights), 1);
        step(3'd1, 1'b0);
        chk("reenter_stay", int'(lights), 1);
        // underflow
        step(3'd0, 1'b0);
        step(3'd7, 1'b0);
        chk("uf_fault", int'(fault), 1);
        chk("uf_lights", int'(lights), 1);
        chk("uf_lock", int'(door_lock), 0);
        chk("uf_vacancy", int'(vacancy), 0);
        step(3'd7, 1'b1);
        chk("uf_ack_fault", int'(fault), 0);
        chk("uf_ack_full", int'(full), 0);
        step(3'd7, 1'b0);
        chk("uf_next_full", int'(full), 1);
        for (int i = 6; i >= 2; i--) step(3'(i), 1'b0);
        // illegal jump while ack held
        step(3'd5, 1'b1);
        chk("jump_fault", int'(fault), 1);
        step(3'd5, 1'b0);
        step(3'd0, 1'b0);
        step(3'd0, 1'b0);
        chk("jump_hold_fault", int'(fault), 1);
        step(3'd0, 1'b1);
        chk("jump_clr_fault", int'(fault), 0);
        chk("jump_clr_lights", int'(lights), 0);
        chk("jump_clr_vacancy", int'(vacancy), 6);
        // async reset mid-vacating
        step(3'd1, 1'b0);
        step(3'd0, 1'b0);
        chk("pre_rst_lights", int'(lights), 1);
        rst = 1'b1;
        #2;
        chk("async_rst_lights", int'(lights), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        step(3'd0, 1'b0);
        step(3'd1, 1'b0);
        chk("post_rst_lights", int'(lights), 1);
        // async reset mid-fault
        step(3'd3, 1'b0);
        chk("pre_rst_fault", int'(fault), 1);
        rst = 1'b1;
        #2;
        chk("async_rst_fault", int'(fault), 0);
        chk("async_rst_fault_lights", int'(lights), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        pcount = 3'd0;
        step(3'd0, 1'b0);
        step(3'd0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/occupancy_monitor.md
# occupancy_monitor

Room-occupancy supervisor that sits directly downstream of the people counter. It consumes the counter's 3-bit `pcount` and drives the lighting, capacity-full indication, door lock and a latched fault flag. Lights are held on for a programmable number of cycles after the room empties. Count wrap-around (under/overflow) or an illegal jump latches a fault until it is acknowledged.

## Interface
Parameters:
- `CAPACITY`, 6: occupancy at or above which the room is full. Legal range 1..7.
- `HOLD_CYCLES`, 16: cycles the lights stay on after `pcount` reaches 0. Must be ≥1. The timer is `$clog2(HOLD_CYCLES+1)` bits wide.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `pcount` input 3: occupancy from the people counter, synchronous to `clk`.
- `ack` input 1: fault acknowledge, level-sampled on `clk`.
- `lights` output 1: room lighting enable.
- `full` output 1: occupancy ≥ `CAPACITY`.
- `door_lock` output 1: entry door locked.
- `fault` output 1: counter wrap or illegal step detected, latched.
- `vacancy` output 3: free places, registered.

## Operation
- Registers: `state`, `prev_pcount[2:0]`, hold timer, `vacancy`.
- `prev_pcount` loads `pcount` every cycle.
- Fault detect (`fault_ev`), evaluated every cycle, has priority over all other transitions. It asserts on any of:
  - `prev_pcount==0 && pcount==7` (underflow);
  - `prev_pcount==7 && pcount==0` (overflow);
  - |`pcount` − `prev_pcount`| > 1 (illegal step).
- States; outputs are Moore-decoded from `state`:
  - EMPTY: lights=0, full=0, door_lock=0, fault=0.
    - If `pcount`≥`CAPACITY` → FULL.
    - Else if `pcount`≠0 → OCCUPIED.
  - OCCUPIED: lights=1, full=0, door_lock=0, fault=0.
    - If `pcount`≥`CAPACITY` → FULL.
    - Else if `pcount`==0 → VACATING, loading timer with `HOLD_CYCLES`−1.
  - FULL: lights=1, full=1, door_lock=1, fault=0.
    - If `pcount`==0 → VACATING, loading timer.
    - Else if `pcount`<`CAPACITY` → OCCUPIED.
  - VACATING: lights=1, full=0, door_lock=0, fault=0.
    - If `pcount`≠0 → OCCUPIED or FULL, using the same threshold rule.
    - Else if timer==0 → EMPTY.
    - Else timer decrements.
  - FAULT: lights=1, full=0, door_lock=0 (fail-safe unlocked), fault=1.
    - If `ack`==1 and no new `fault_ev` → EMPTY when `pcount`==0, else OCCUPIED.
    - FULL is not entered directly from FAULT; the next cycle re-evaluates the threshold.
- From any state, `fault_ev` → FAULT.
- `vacancy`, updated every cycle from the current `pcount`:
  - 0 if next state is FAULT;
  - else `CAPACITY`−`pcount` if `pcount`<`CAPACITY`;
  - else 0.
  - Saturating, never negative.
- Simultaneous events:
  - `fault_ev` with `ack` → stay in FAULT.
  - In VACATING, `pcount`≠0 with timer==0 → occupancy wins, so no EMPTY.
- The timer is only meaningful in VACATING and is reloaded on every VACATING entry.

## Timing
- Reset (async, immediate): state=EMPTY, `prev_pcount`=0, timer=0, `lights`=0, `full`=0, `door_lock`=0, `fault`=0, `vacancy`=`CAPACITY`.
- Reset mid-VACATING or mid-FAULT drops `lights` and `fault` asynchronously, with no hold period.
- Latency: a `pcount` value present before edge N is reflected on all outputs immediately after edge N. The module adds one cycle relative to the counter.
- Hold: VACATING entered at edge E with `pcount` held at 0 → `lights` falls after edge E+`HOLD_CYCLES`. Lights stay on exactly `HOLD_CYCLES` cycles in VACATING.
- `fault` rises the cycle after the offending `pcount` sample. It falls after the first edge where `ack`=1 and no new `fault_ev` is present.
- No combinational path from inputs to outputs.

## Test plan
All scenarios use `CAPACITY`=6, `HOLD_CYCLES`=4.
- Reset then idle: `pcount`=0 → all outputs 0 except `vacancy`=6; state EMPTY.
- Ramp: `pcount` steps 0→1→…→6, one step per cycle → `lights`=1 from the first step; `full`=`door_lock`=1 one edge after 6 is sampled; `vacancy` goes 5,4,…,0. Then stepping to 5 → `full`=0, `vacancy`=1.
- Vacate: `pcount` 1→0 and held → `lights` stays 1 for 4 cycles then 0. Repeat with `pcount`=1 on the 4th VACATING cycle → `lights` stays 1, state OCCUPIED.
- Underflow: `pcount` 0→7 → `fault`=1, `lights`=1, `door_lock`=0, `vacancy`=0. `ack`=1 for one cycle with `pcount`=7 → OCCUPIED, then FULL the following cycle.
- Illegal jump 2→5 while `ack`=1 → `fault` asserts and stays (fault priority). Deassert `ack`, then reassert with `pcount` stable at 0 → EMPTY.
- Async reset asserted mid-VACATING between clock edges → `lights` drops with no edge; after release, ramp 0→1 → `lights`=1 one edge later.
